fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline buffer. Owns the word-addressed PC.
//  Issues in-order requests to instruction memory over a req/gnt + rvalid interface.
//  Buffers returned words in a small FIFO and presents {instr, pc, pc+1} to IF/ID.
//  Handles stalls and branch/jump redirects, discarding stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset
//  FIFO_DEPTH  2      instruction FIFO entries; also the outstanding-request credit limit (2..8)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  stall           in   1   IF/ID must hold; current fd_* is not consumed this cycle
//  redirect_valid  in   1   branch/jump taken; restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target (word address)
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address (= pc)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response word valid (in order, >=1 cycle after gnt)
//  imem_rdata      in   32  response instruction word
//  fd_valid        out  1   fd_* holds a real instruction
//  fd_instr        out  32  instruction; NOP when fd_valid=0
//  fd_pc           out  32  PC of fd_instr
//  fd_pc_plus1     out  32  fd_pc + 1, modulo 2^32
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=FETCH.
//    Outputs during/after reset: fd_valid=0, fd_instr=NOP, fd_pc=0, fd_pc_plus1=1, imem_req=0 while rst=1.
//  FSM FETCH:
//    imem_req = (outstanding + occupancy < FIFO_DEPTH) && !redirect_valid.
//    On req&&gnt: pc<=pc+1 (wraps 32'hFFFFFFFF->0), outstanding++.
//    imem_addr stable while req && !gnt.
//  FSM DRAIN: imem_req=0. Each rvalid decrements drop_cnt and outstanding; the word is discarded.
//    Return to FETCH in the cycle after drop_cnt reaches 0.
//  Redirect (any state):
//    pc<=redirect_pc; FIFO flushed; fd_valid=0 next cycle.
//    drop_cnt <= outstanding_next (includes a request granted in the same cycle, excludes a response accepted in the same cycle).
//    State -> DRAIN if drop_cnt_next>0, else FETCH.
//  Redirect beats stall; redirect during DRAIN reloads drop_cnt with current in-flight count.
//  Response (FETCH, rvalid): push {rdata, pc_of_resp}; pc_of_resp tracked by response-PC counter.
//    Response-PC counter loaded on redirect, incremented per kept response. Never pushes into a full FIFO (credit rule guarantees this).
//  Output: fd_* = FIFO head; pop when fd_valid && !stall. Push and pop in the same cycle allowed at full.
//  Latency: zero-wait memory (gnt same cycle, rvalid next) -> instr visible on fd_* 2 cycles after req&&gnt.
//    Sustained throughput: 1 instr/cycle at FIFO_DEPTH>=2.
//  rst mid-operation: all state cleared; responses for pre-reset requests are the memory's responsibility to squash.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//    When FIFO empty, state FETCH and rvalid, imem_rdata drives fd_* combinationally (fd_valid=1).
//    If !stall the word is consumed without a push; if stall it is pushed.
//    Latency drops to 1 cycle after req&&gnt.
//  FETCH_BYPASS_EN undefined: every response goes through the FIFO; no imem_rdata->fd_* combinational path.
// STRUCTURE
//  cpu_pkg: NOP encoding (32'h0), XLEN=32, fetch state enum {FETCH, DRAIN}.
//  Sub-module fetch_fifo (DEPTH, WIDTH=64 {instr,pc}): sync push/pop/flush, full/empty/count, registered head.
// TESTING
//  T1 reset: rst=1 two cycles, RESET_PC=0x40 -> fd_valid=0, imem_req=0.
//     Then first req addr=0x40; zero-wait mem -> fd_valid=1, fd_pc=0x40, fd_pc_plus1=0x41 two cycles after gnt.
//  T2 streaming, zero-wait mem, stall=0:
//     -> fd_pc = 0x40,0x41,0x42,... on consecutive cycles, fd_valid continuous.
//  T3 stall=1 for 3 cycles with FIFO_DEPTH=2:
//     -> fd_* held constant; imem_req drops after 2 credits used; no word lost or duplicated after release.
//  T4 redirect to 0x100 with 2 responses in flight (mem latency 3):
//     -> both stale responses dropped in DRAIN; next fd_pc=0x100; no stale fd_valid.
//  T5 redirect coincident with req&&gnt and with stall=1:
//     -> granted word dropped; redirect wins over stall; fd_valid=0 next cycle.
//  T6 wrap: redirect_pc=32'hFFFFFFFF -> fd_pc=0xFFFFFFFF with fd_pc_plus1=0, next fd_pc=0.
//     With FETCH_BYPASS_EN, T1 latency = 1 cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction word width, NOP encoding, fetch FSM states
// and the {instr, pc} payload carried through the fetch FIFO.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {instr, pc} entries; flush empties it in one cycle,
// head is read straight from the storage registers.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   // A pop at full frees the slot the simultaneous push lands in
   always_comb begin
      push_ok = push_i && (!full_o || pop_i);
      pop_ok  = pop_i && !empty_o;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) wr_d = ptr_inc(wr_q);
         if (pop_ok)  rd_d = ptr_inc(rd_q);
         cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses
// and presents {instr, pc, pc+1} to IF/ID. FETCH_BYPASS_EN adds an imem_rdata->fd_* bypass.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            fd_valid,
   output logic [XLEN-1:0] fd_instr,
   output logic [XLEN-1:0] fd_pc,
   output logic [XLEN-1:0] fd_pc_plus1
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d;

   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t    fifo_wdata, fifo_rdata;
   logic            fire, keep;
   logic [SUM_W-1:0] credits_used;
`ifdef FETCH_BYPASS_EN
   logic            byp;
`endif

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (redirect_valid),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign imem_addr = pc_q;

   // Request credit, response handling and FETCH/DRAIN next-state
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      fifo_pop   = !fifo_empty && !stall;
      fifo_wdata = '{instr: imem_rdata, pc: rsp_pc_q};
      // A head consumed this cycle frees its slot, which keeps streaming at 1 instr/cycle
      credits_used = SUM_W'(outst_q) + SUM_W'(fifo_count) - SUM_W'(fifo_pop);
      imem_req   = !rst && (state_q == FETCH) && !redirect_valid
                   && (credits_used < SUM_W'(FIFO_DEPTH));
      fire       = imem_req && imem_gnt;
      outst_d    = outst_q + CNT_W'(fire) - CNT_W'(imem_rvalid);
      keep       = !rst && (state_q == FETCH) && imem_rvalid && !redirect_valid;
`ifdef FETCH_BYPASS_EN
      byp        = !rst && fifo_empty && (state_q == FETCH) && imem_rvalid;
      fifo_push  = keep && !(byp && !stall) && (!fifo_full || fifo_pop);
`else
      fifo_push  = keep && (!fifo_full || fifo_pop);
`endif

      if (redirect_valid) begin
         pc_d     = redirect_pc;
         rsp_pc_d = redirect_pc;
         drop_d   = outst_d;
         state_d  = (outst_d != '0) ? DRAIN : FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (fire) pc_d = pc_q + XLEN'(1);
               if (keep) rsp_pc_d = rsp_pc_q + XLEN'(1);
            end
            DRAIN: begin
               if (drop_q == '0) begin
                  state_d = FETCH;
               end else if (imem_rvalid) begin
                  drop_d = drop_q - CNT_W'(1);
                  if (drop_q == CNT_W'(1)) state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   // IF/ID view of the FIFO head (or the bypassed response word)
   always_comb begin
      fd_valid = !rst && !fifo_empty;
      fd_instr = fifo_rdata.instr;
      fd_pc    = fifo_rdata.pc;
`ifdef FETCH_BYPASS_EN
      if (byp) begin
         fd_valid = 1'b1;
         fd_instr = imem_rdata;
         fd_pc    = rsp_pc_q;
      end
`endif
      if (!fd_valid) begin
         fd_instr = NOP;
         fd_pc    = '0;
      end
      fd_pc_plus1 = fd_pc + XLEN'(1);
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed reset/stream/stall/redirect/wrap scenarios
// followed by randomized traffic against a transaction-level program-order model.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h40;
   localparam int unsigned DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
   localparam int FIRST_LAT = 1;
`else
   localparam int FIRST_LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        fd_valid;
   logic [31:0] fd_instr, fd_pc, fd_pc_plus1;

   fetch_stage #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .fd_valid       (fd_valid),
      .fd_instr       (fd_instr),
      .fd_pc          (fd_pc),
      .fd_pc_plus1    (fd_pc_plus1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int          checks = 0, errors = 0;
   req_t        pend[$];
   int          cyc = 0, last_due = 0, consumed = 0;
   int          lat_min = 1, lat_max = 1, gnt_pct = 100;
   logic [31:0] exp_fetch = RST_PC, exp_pc = RST_PC;
   bit          prev_redir = 1'b0;
   logic        s_req, s_fd_valid;
   logic [31:0] s_addr, s_fd_instr, s_fd_pc, s_fd_plus1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock: memory drives response/grant, outputs are checked, then the model steps
   task automatic cycle();
      req_t r;
      bit   rv, g;
      int   lat, infl;
      rv = 1'b0;
      if (!rst && pend.size() > 0) rv = (pend[0].due <= cyc);
      imem_rvalid = rv;
      imem_rdata  = rv ? instr_of(pend[0].addr) : $urandom;
      #1;
      g = imem_req && (gnt_pct >= 100 || $urandom_range(99) < 32'(gnt_pct));
      imem_gnt = g;
      #1;
      s_req = imem_req;  s_addr = imem_addr;  s_fd_valid = fd_valid;
      s_fd_instr = fd_instr;  s_fd_pc = fd_pc;  s_fd_plus1 = fd_pc_plus1;
      if (rst) begin
         check("rst_req", 32'(imem_req), 32'd0);
         check("rst_fd_valid", 32'(fd_valid), 32'd0);
         check("rst_fd_instr", fd_instr, NOP);
      end else begin
         if (imem_req) check("imem_addr", imem_addr, exp_fetch);
         if (redirect_valid) check("req_during_redirect", 32'(imem_req), 32'd0);
         if (prev_redir) check("fd_valid_after_redirect", 32'(fd_valid), 32'd0);
         if (fd_valid) begin
            check("fd_pc", fd_pc, exp_pc);
            check("fd_instr", fd_instr, instr_of(exp_pc));
            check("fd_pc_plus1", fd_pc_plus1, exp_pc + 32'd1);
         end else begin
            check("fd_nop", fd_instr, NOP);
         end
         if (g) begin
            infl = pend.size() + 1 - (rv ? 1 : 0);
            check("credit_limit", 32'(infl <= int'(DEPTH)), 32'd1);
         end
      end
      @(posedge clk);
      if (rst) begin
         pend.delete();
         exp_fetch = RST_PC;
         exp_pc    = RST_PC;
         last_due  = 0;
      end else begin
         if (rv) void'(pend.pop_front());
         if (g) begin
            lat    = int'($urandom_range(32'(lat_max), 32'(lat_min)));
            r.addr = exp_fetch;
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            pend.push_back(r);
            exp_fetch = exp_fetch + 32'd1;
         end
         if (redirect_valid) begin
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
         end else if (s_fd_valid && !stall) begin
            exp_pc = exp_pc + 32'd1;
            consumed++;
         end
      end
      prev_redir = !rst && redirect_valid;
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int max_cyc, output bit found);
      found = 1'b0;
      for (int i = 0; i < max_cyc && !found; i++) begin
         cycle();
         found = s_fd_valid;
      end
   endtask

   initial begin
      logic [31:0] held, rpc;
      bit          found;
      int          c0;
      rst = 1'b1;  stall = 1'b0;  redirect_valid = 1'b0;  redirect_pc = '0;
      imem_gnt = 1'b0;  imem_rvalid = 1'b0;  imem_rdata = '0;
      @(negedge clk);

      // T1: reset values, first request and first-instruction latency
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("t1_rst_fd_pc", s_fd_pc, 32'd0);
         check("t1_rst_fd_pc_plus1", s_fd_plus1, 32'd1);
      end
      rst = 1'b0;
      for (int k = 0; k <= FIRST_LAT; k++) begin
         cycle();
         if (k == 0) begin
            check("t1_first_req", 32'(s_req), 32'd1);
            check("t1_first_addr", s_addr, RST_PC);
         end
         if (k < FIRST_LAT) check("t1_early_valid", 32'(s_fd_valid), 32'd0);
         else begin
            check("t1_valid", 32'(s_fd_valid), 32'd1);
            check("t1_pc", s_fd_pc, RST_PC);
            check("t1_pc_plus1", s_fd_plus1, RST_PC + 32'd1);
         end
      end

      // T2: back-to-back streaming
      for (int j = 1; j <= 8; j++) begin
         cycle();
         check("t2_valid", 32'(s_fd_valid), 32'd1);
         check("t2_pc", s_fd_pc, RST_PC + 32'(j));
      end

      // T3: three-cycle stall
      stall = 1'b1;
      cycle();
      held = s_fd_pc;
      check("t3_valid", 32'(s_fd_valid), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("t3_hold", s_fd_pc, held);
         check("t3_req_off", 32'(s_req), 32'd0);
      end
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_release_valid", 32'(s_fd_valid), 32'd1);
         check("t3_release_pc", s_fd_pc, held + 32'(i));
      end

      // T4: redirect with two responses in flight, latency 3
      lat_min = 3;  lat_max = 3;
      for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
      check("t4_two_in_flight", 32'(pend.size()), 32'd2);
      redirect_valid = 1'b1;  redirect_pc = 32'h100;
      cycle();
      redirect_valid = 1'b0;
      wait_valid(30, found);
      check("t4_found", 32'(found), 32'd1);
      check("t4_pc", s_fd_pc, 32'h100);

      // T5: redirect together with stall
      lat_min = 1;  lat_max = 1;
      for (int i = 0; i < 4; i++) cycle();
      stall = 1'b1;  redirect_valid = 1'b1;  redirect_pc = 32'h200;
      cycle();
      check("t5_req", 32'(s_req), 32'd0);
      check("t5_valid_before", 32'(s_fd_valid), 32'd1);
      stall = 1'b0;  redirect_valid = 1'b0;
      cycle();
      check("t5_valid_next", 32'(s_fd_valid), 32'd0);
      wait_valid(30, found);
      check("t5_found", 32'(found), 32'd1);
      check("t5_pc", s_fd_pc, 32'h200);

      // T6: PC wrap
      redirect_valid = 1'b1;  redirect_pc = 32'hFFFF_FFFF;
      cycle();
      redirect_valid = 1'b0;
      wait_valid(30, found);
      check("t6_found", 32'(found), 32'd1);
      check("t6_pc", s_fd_pc, 32'hFFFF_FFFF);
      check("t6_pc_plus1", s_fd_plus1, 32'h0);
      cycle();
      check("t6_wrap_valid", 32'(s_fd_valid), 32'd1);
      check("t6_wrap_pc", s_fd_pc, 32'h0);

      // Randomized traffic: variable latency, grant, stall, redirect, occasional reset
      lat_min = 1;  lat_max = 4;  gnt_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         stall          = ($urandom_range(3) == 0);
         redirect_valid = ($urandom_range(19) == 0);
         rpc            = $urandom;
         if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFFD + 32'($urandom_range(2));
         redirect_pc    = rpc;
         rst            = ($urandom_range(499) == 0);
         cycle();
      end
      rst = 1'b0;  stall = 1'b0;  redirect_valid = 1'b0;
      lat_min = 1;  lat_max = 1;  gnt_pct = 100;
      c0 = consumed;
      for (int i = 0; i < 40; i++) cycle();
      check("final_progress", 32'((consumed - c0) >= 30), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
